fifo_rr_arbiter: RTL

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

---
 rtl/fifo_rr_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter
//
// Round-robin arbiter that merges N_SRC word sources into a single downstream
// FIFO write port. The arbiter grants one source at a time for a burst of up
// to MAX_BURST words. It then drops to IDLE for one cycle and picks the next
// requester, searching upward from the last granted index.
//
// Handshake: source i offers a word with SRC_VALID[i]. The word is taken in the
// same cycle that SRC_READY[i] is high. SRC_READY is purely combinational and
// is high only when all of the following hold: source i owns the grant, it is
// valid, it is enabled, fifo_full is low and reset is low. One cycle after a
// word is taken, it appears on FIFO_DATA together with a single-cycle
// FIFO_WRITE strobe. fifo_full is an almost-full flag, so the one-cycle output
// stage always has room.
//
// Ports
//   BUS_CLK     in   clock, rising edge
//   BUS_RST     in   synchronous active-high reset
//   SRC_EN      in   [N_SRC]             per-source enable mask
//   SRC_VALID   in   [N_SRC]             per-source word valid
//   SRC_DATA    in   [N_SRC*DATA_WIDTH]  source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   SRC_READY   out  [N_SRC]             word of source i accepted this cycle
//   fifo_full   in   downstream almost-full
//   FIFO_WRITE  out  write strobe, one cycle after the accepting cycle
//   FIFO_DATA   out  [DATA_WIDTH] written word; holds value between writes
//   GRANT       out  [3] current / last granted source index
//   BUSY        out  high while the FSM is in GRANT (FSM state observation)
// -----------------------------------------------------------------------------
module fifo_rr_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                        BUS_CLK,
    input  logic                        BUS_RST,
    input  logic [N_SRC-1:0]            SRC_EN,
    input  logic [N_SRC-1:0]            SRC_VALID,
    input  logic [N_SRC*DATA_WIDTH-1:0] SRC_DATA,
    output logic [N_SRC-1:0]            SRC_READY,
    input  logic                        fifo_full,
    output logic                        FIFO_WRITE,
    output logic [DATA_WIDTH-1:0]       FIFO_DATA,
    output logic [2:0]                  GRANT,
    output logic                        BUSY
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [2:0]              grant_q, grant_d;
    logic [7:0]              burst_q, burst_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    // Requests are widened to 8 bits so the 3-bit grant index can select
    // any bit directly, whatever N_SRC is.
    logic [7:0]              req_ext;
    logic                    owner_req;
    logic                    xfer;
    logic [7:0]              burst_inc;
    logic                    burst_last;
    logic [2:0]              next_grant;
    logic [DATA_WIDTH-1:0]   sel_word;

    assign req_ext    = 8'(SRC_VALID & SRC_EN);
    assign owner_req  = req_ext[grant_q];
    // Reset gates the accept path so that no word is taken during a reset
    // cycle. Any word taken in such a cycle would be lost by the output stage.
    assign xfer       = (state_q == ST_GRANT) && owner_req && !fifo_full && !BUS_RST;
    assign SRC_READY  = xfer ? (ONE_HOT0 << grant_q) : '0;
    assign burst_inc  = burst_q + 8'd1;
    assign burst_last = (burst_inc == 8'(MAX_BURST));

    // Round-robin search: the candidate at distance k from the last grant is
    // (grant_q + k) mod N_SRC, for k = 1..N_SRC. Distance N_SRC is the last
    // granted source itself, so a lone requester wins again. The loop runs
    // from the farthest candidate to the nearest, so the nearest requesting
    // candidate is the last one written and therefore takes priority.
    always_comb begin
        logic [3:0] cand;
        next_grant = grant_q;
        cand       = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = {1'b0, grant_q} + 4'(k);
            if (cand >= 4'(N_SRC)) begin
                cand = cand - 4'(N_SRC);
            end
            if (req_ext[cand[2:0]]) begin
                next_grant = cand[2:0];
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                sel_word = SRC_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and output-stage logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        wr_d    = xfer;
        data_d  = xfer ? sel_word : data_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_ext) begin
                    grant_d = next_grant;
                    burst_d = 8'd0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // If the owner drops valid or enable, the grant is released at
                // once. If fifo_full alone blocks the owner, the grant is held
                // and the counter does not change.
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    burst_d = burst_inc;
                    if (burst_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q <= ST_IDLE;
            // Starting from the top index makes the first search after reset
            // begin at source 0.
            grant_q <= 3'(N_SRC - 1);
            burst_q <= 8'd0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign FIFO_WRITE = wr_q;
    assign FIFO_DATA  = data_q;
    assign GRANT      = grant_q;
    assign BUSY       = (state_q == ST_GRANT);

endmodule
